// File: rtl/tl_traffic_gen.sv
// TileLink-UL A/D traffic generator with a shadow-memory scoreboard.
// Pre-fills a DEPTH-word window, issues NUM_TXN random Get/Put requests and checks every response.
module tl_traffic_gen #(
  parameter int             ADDR_BITS   = 32,
  parameter int             DATA_BYTES  = 8,
  parameter int             SOURCE_BITS = 4,
  parameter int             NUM_SOURCES = 4,
  parameter int             DEPTH       = 16,
  parameter logic [ADDR_BITS-1:0] BASE_ADDR = '0,
  parameter int             NUM_TXN     = 64,
  parameter logic [31:0]    SEED        = 32'h1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    a_valid,
  input  logic                    a_ready,
  output logic [2:0]              a_opcode,
  output logic [3:0]              a_size,
  output logic [SOURCE_BITS-1:0]  a_source,
  output logic [ADDR_BITS-1:0]    a_address,
  output logic [DATA_BYTES-1:0]   a_mask,
  output logic [DATA_BYTES*8-1:0] a_data,
  input  logic                    d_valid,
  output logic                    d_ready,
  input  logic [2:0]              d_opcode,
  input  logic [SOURCE_BITS-1:0]  d_source,
  input  logic [DATA_BYTES*8-1:0] d_data,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [15:0]             err_count,
  output logic [15:0]             txn_count,
  output logic [2:0]              dbg_state
);
  localparam int          DW          = DATA_BYTES * 8;
  localparam int          IW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  SIZE        = 4'($clog2(DATA_BYTES));
  localparam logic [31:0] SEED_NZ     = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [31:0] TAPS        = 32'h8020_0003;
  localparam logic [2:0]  OP_PUT_FULL = 3'd0;
  localparam logic [2:0]  OP_PUT_PART = 3'd1;
  localparam logic [2:0]  OP_GET      = 3'd4;
  localparam logic [2:0]  D_ACK       = 3'd0;
  localparam logic [2:0]  D_ACK_DATA  = 3'd1;

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e                 state_q, state_d;
  logic [31:0]            lfsr_q, lfsr_d;
  logic [IW-1:0]          init_idx_q, init_idx_d;
  logic [31:0]            issued_q, issued_d;
  logic [15:0]            err_q, err_d, txn_q, txn_d;
  logic                   hold_q, hold_d;
  logic [SOURCE_BITS-1:0] hold_src_q, hold_src_d;
  logic [NUM_SOURCES-1:0] busy_q, busy_d, get_q, get_d;
  logic [IW-1:0]          sidx_q [NUM_SOURCES];
  logic [IW-1:0]          sidx_d [NUM_SOURCES];
  logic [DW-1:0]          sexp_q [NUM_SOURCES];
  logic [DW-1:0]          sexp_d [NUM_SOURCES];
  logic [DW-1:0]          shadow_q [DEPTH];
  logic [DW-1:0]          shadow_d [DEPTH];

  logic                   issuing, a_fire, d_fire, d_err, free_found, hazard;
  logic                   d_hit_busy, d_hit_get;
  logic [DW-1:0]          d_hit_exp, cand_data;
  logic [IW-1:0]          cand_idx;
  logic [2:0]             cand_op;
  logic [DATA_BYTES-1:0]  cand_mask, part_mask;
  logic [SOURCE_BITS-1:0] free_src, issue_src;

  always_comb begin
    cand_idx  = (state_q == S_INIT) ? init_idx_q : lfsr_q[IW-1:0];
    part_mask = lfsr_q[8 +: DATA_BYTES];
    cand_op   = OP_PUT_FULL;
    cand_mask = '1;
    if (state_q == S_RUN) begin
      case (lfsr_q[31:30])
        2'b10:   cand_op = OP_PUT_FULL;
        2'b11: begin
          cand_op = OP_PUT_PART;
          if (part_mask != '0) cand_mask = part_mask;
        end
        default: cand_op = OP_GET;
      endcase
    end
    cand_data = '0;
    if (cand_op != OP_GET) begin
      for (int b = 0; b < DATA_BYTES; b++) cand_data[b*8 +: 8] = lfsr_q[(b % 4)*8 +: 8];
    end
    free_found = 1'b0;
    free_src   = '0;
    hazard     = 1'b0;
    for (int s = NUM_SOURCES - 1; s >= 0; s--) begin
      if (!busy_q[s]) begin
        free_found = 1'b1;
        free_src   = SOURCE_BITS'(s);
      end
      if (busy_q[s] && !get_q[s] && sidx_q[s] == cand_idx) hazard = 1'b1;
    end
    // A stalled request keeps its source even if a lower slot frees meanwhile.
    issue_src = hold_q ? hold_src_q : free_src;
    issuing   = (state_q == S_INIT || state_q == S_RUN) && (hold_q || (free_found && !hazard));
  end

  assign a_valid   = issuing;
  assign a_opcode  = issuing ? cand_op : '0;
  assign a_size    = issuing ? SIZE : '0;
  assign a_source  = issuing ? issue_src : '0;
  assign a_address = issuing ? BASE_ADDR + ADDR_BITS'(cand_idx) * ADDR_BITS'(DATA_BYTES) : '0;
  assign a_mask    = issuing ? cand_mask : '0;
  assign a_data    = issuing ? cand_data : '0;
  assign d_ready   = (state_q == S_INIT || state_q == S_RUN || state_q == S_DRAIN);
  assign a_fire    = issuing && a_ready;
  assign d_fire    = d_valid && d_ready;

  always_comb begin
    d_hit_busy = 1'b0;
    d_hit_get  = 1'b0;
    d_hit_exp  = '0;
    busy_d     = busy_q;
    get_d      = get_q;
    sidx_d     = sidx_q;
    sexp_d     = sexp_q;
    shadow_d   = shadow_q;
    for (int s = 0; s < NUM_SOURCES; s++) begin
      if (d_source == SOURCE_BITS'(s)) begin
        d_hit_busy = busy_q[s];
        d_hit_get  = get_q[s];
        d_hit_exp  = sexp_q[s];
      end
      if (d_fire && d_source == SOURCE_BITS'(s)) busy_d[s] = 1'b0;
      if (a_fire && issue_src == SOURCE_BITS'(s)) begin
        busy_d[s] = 1'b1;
        get_d[s]  = (cand_op == OP_GET);
        sidx_d[s] = cand_idx;
        sexp_d[s] = shadow_q[cand_idx];
      end
    end
    if (a_fire && cand_op != OP_GET) begin
      for (int b = 0; b < DATA_BYTES; b++) begin
        if (cand_mask[b]) shadow_d[cand_idx][b*8 +: 8] = cand_data[b*8 +: 8];
      end
    end
    d_err = !d_hit_busy ||
            (d_hit_get ? (d_opcode != D_ACK_DATA || d_data != d_hit_exp) : (d_opcode != D_ACK));
  end

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    issued_d   = issued_q;
    err_d      = err_q;
    txn_d      = txn_q;
    hold_d     = issuing && !a_ready;
    hold_src_d = issue_src;
    lfsr_d     = a_fire ? ({1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? TAPS : 32'h0)) : lfsr_q;
    if (d_fire) begin
      if (d_err && err_q != 16'hFFFF) err_d = err_q + 16'd1;
      if (txn_q != 16'hFFFF) txn_d = txn_q + 16'd1;
    end
    case (state_q)
      S_IDLE, S_DONE: if (start) begin
        state_d    = S_INIT;
        init_idx_d = '0;
        issued_d   = '0;
        err_d      = '0;
        txn_d      = '0;
      end
      S_INIT: if (a_fire) begin
        init_idx_d = init_idx_q + 1'b1;
        if (init_idx_q == IW'(DEPTH - 1)) state_d = (NUM_TXN == 0) ? S_DRAIN : S_RUN;
      end
      S_RUN: if (a_fire) begin
        issued_d = issued_q + 32'd1;
        if (issued_q == 32'(NUM_TXN - 1)) state_d = S_DRAIN;
      end
      // Looking at next-cycle occupancy lets done follow the last response by one cycle.
      S_DRAIN: if (busy_d == '0) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      lfsr_q     <= SEED_NZ;
      init_idx_q <= '0;
      issued_q   <= '0;
      err_q      <= '0;
      txn_q      <= '0;
      hold_q     <= 1'b0;
      hold_src_q <= '0;
      busy_q     <= '0;
      get_q      <= '0;
      sidx_q     <= '{default: '0};
      sexp_q     <= '{default: '0};
      shadow_q   <= '{default: '0};
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      init_idx_q <= init_idx_d;
      issued_q   <= issued_d;
      err_q      <= err_d;
      txn_q      <= txn_d;
      hold_q     <= hold_d;
      hold_src_q <= hold_src_d;
      busy_q     <= busy_d;
      get_q      <= get_d;
      sidx_q     <= sidx_d;
      sexp_q     <= sexp_d;
      shadow_q   <= shadow_d;
    end
  end

  assign busy      = d_ready;
  assign done      = (state_q == S_DONE);
  assign pass      = (state_q == S_DONE) && (err_q == 16'd0);
  assign err_count = err_q;
  assign txn_count = txn_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_tl_traffic_gen.sv
// Bench for tl_traffic_gen: ideal memory slave with configurable A stalls, response delay,
// reordering and fault injection; checks status, A-channel protocol and trace repeatability.
module tb_tl_traffic_gen;
  localparam int DB    = 8;
  localparam int DW    = 64;
  localparam int SB    = 4;
  localparam int NS    = 4;
  localparam int DEPTH = 16;
  localparam int NTXN  = 64;
  localparam int W     = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          a_valid;
  logic          a_ready = 1'b0;
  logic [2:0]    a_opcode;
  logic [3:0]    a_size;
  logic [SB-1:0] a_source;
  logic [31:0]   a_address;
  logic [DB-1:0] a_mask;
  logic [DW-1:0] a_data;
  logic          d_valid = 1'b0;
  logic          d_ready;
  logic [2:0]    d_opcode = 3'd0;
  logic [SB-1:0] d_source = '0;
  logic [DW-1:0] d_data = '0;
  logic          busy, done, pass;
  logic [15:0]   err_count, txn_count;
  logic [2:0]    dbg_state;

  tl_traffic_gen #(
    .ADDR_BITS(32), .DATA_BYTES(DB), .SOURCE_BITS(SB), .NUM_SOURCES(NS),
    .DEPTH(DEPTH), .BASE_ADDR(32'h0), .NUM_TXN(NTXN), .SEED(32'h1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_size(a_size),
    .a_source(a_source), .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_source(d_source),
    .d_data(d_data), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .txn_count(txn_count), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state
  typedef struct {
    logic [SB-1:0] src;
    logic          is_get;
    logic [3:0]    idx;
    logic [DW-1:0] data;
    int            due;
  } rsp_t;

  int            n_tests = 0;
  int            n_fail = 0;
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  got_q[$];
  rsp_t          pend_q[$];
  logic [DW-1:0] mem [DEPTH];
  int            put_out [DEPTH];
  int            a_fires, d_fires, out_cnt, max_out, hazards, unstable, proto_bad;
  bit            to;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; a_ready = 1'b0; d_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Driver + ideal memory slave. Inputs change on negedge; fires happen at the next posedge.
  // trace entry: {pad, cyc[126:111], src[110:107], op[106:104], mask[103:96], addr[95:64], data[63:0]}
  task automatic run_traffic(input int stall, input int delay, input bit skew, input bit corrupt,
                             input bit spurious, input int abort_run, output bit timed_out);
    int           c, run_cyc, wait_cnt, pick;
    bit           first_get_seen, prev_stall, a_fire, d_fire, is_get;
    logic [W-1:0] f, prev_f;
    logic [3:0]   idx;
    rsp_t         r;
    got_q.delete();
    pend_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = '0;
      put_out[i] = 0;
    end
    a_fires = 0; d_fires = 0; out_cnt = 0; max_out = 0;
    hazards = 0; unstable = 0; proto_bad = 0;
    timed_out = 1'b0; run_cyc = 0; wait_cnt = 0;
    first_get_seen = 1'b0; prev_stall = 1'b0; prev_f = '0;
    @(negedge clk);
    start = 1'b1;
    c = 0;
    @(negedge clk);
    start = 1'b0;
    c = 1;
    while (!done) begin
      if (c > 4000) begin
        timed_out = 1'b1;
        break;
      end
      if (abort_run > 0 && dbg_state == 3'd2) begin
        run_cyc++;
        if (run_cyc >= abort_run) break;
      end
      f = {1'b0, 16'(c), a_source, a_opcode, a_mask, a_address, a_data};
      if (prev_stall && (!a_valid || f[110:0] !== prev_f[110:0])) unstable++;
      a_ready = a_valid && (wait_cnt >= stall);
      a_fire  = a_valid && a_ready;
      if (a_valid && !a_ready) wait_cnt++;
      prev_stall = a_valid && !a_ready;
      prev_f = f;
      if (a_fire) begin
        wait_cnt = 0;
        idx = a_address[6:3];
        is_get = (a_opcode == 3'd4);
        if (a_size != 4'd3 || a_address[2:0] != 3'd0 || a_address[31:7] != '0 || a_source >= NS)
          proto_bad++;
        case (a_opcode)
          3'd4:    if (a_mask != 8'hFF || a_data != '0) proto_bad++;
          3'd0:    if (a_mask != 8'hFF) proto_bad++;
          3'd1:    ;
          default: proto_bad++;
        endcase
        if (put_out[idx] > 0) hazards++;
        r.src = a_source;
        r.is_get = is_get;
        r.idx = idx;
        r.data = mem[idx];
        if (!is_get) begin
          for (int b = 0; b < DB; b++) if (a_mask[b]) mem[idx][b*8 +: 8] = a_data[b*8 +: 8];
          put_out[idx]++;
        end else if (corrupt && !first_get_seen) begin
          r.data[0] = ~r.data[0];
          first_get_seen = 1'b1;
        end
        r.due = c + delay + (skew ? (3 - (a_fires % 4)) * 4 : 0);
        pend_q.push_back(r);
        a_fires++;
        out_cnt++;
        if (out_cnt > max_out) max_out = out_cnt;
        got_q.push_back(f);
      end
      d_valid = 1'b0;
      pick = -1;
      if (spurious && c == 1) begin
        d_valid = 1'b1; d_source = 4'd7; d_opcode = 3'd0; d_data = '0;
      end else begin
        for (int i = 0; i < pend_q.size(); i++) begin
          if (pend_q[i].due <= c) begin
            pick = i;
            break;
          end
        end
        if (pick >= 0) begin
          d_valid  = 1'b1;
          d_source = pend_q[pick].src;
          d_opcode = pend_q[pick].is_get ? 3'd1 : 3'd0;
          d_data   = pend_q[pick].is_get ? pend_q[pick].data : '0;
        end
      end
      d_fire = d_valid && d_ready;
      if (d_fire && pick >= 0) begin
        if (!pend_q[pick].is_get) put_out[pend_q[pick].idx]--;
        out_cnt--;
        d_fires++;
        pend_q.delete(pick);
      end
      @(negedge clk);
      c++;
    end
    a_ready = 1'b0;
    d_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_a_side", W'({a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data}), 0);
    check_eq("reset_status", W'({d_ready, busy, done, pass, err_count, txn_count}), 0);
    check_eq("reset_state", W'(dbg_state), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // zero-wait reference run
    run_traffic(0, 1, 1'b0, 1'b0, 1'b0, 0, to);
    check_eq("ref_timeout", W'(to), 0);
    check_eq("ref_done_pass", W'({done, pass}), 2'b11);
    check_eq("ref_err", W'(err_count), 0);
    check_eq("ref_txn", W'(txn_count), 80);
    check_eq("ref_a_fires", W'(a_fires), 80);
    check_eq("ref_d_fires", W'(d_fires), 80);
    check_eq("ref_proto", W'(proto_bad), 0);
    check_eq("ref_hazard", W'(hazards), 0);
    check_eq("ref_idle_outputs", W'({a_valid, d_ready, busy}), 0);
    check_eq("init0_cycle", W'(got_q[0][126:111]), 1);
    check_eq("init0_addr", W'(got_q[0][95:64]), 32'h0);
    check_eq("init0_data", W'(got_q[0][63:0]), 64'h00000001_00000001);
    check_eq("init0_op_mask", W'(got_q[0][106:96]), {3'd0, 8'hFF});
    check_eq("init1_addr", W'(got_q[1][95:64]), 32'h8);
    check_eq("init1_data", W'(got_q[1][63:0]), 64'h80200003_80200003);
    check_eq("init2_addr", W'(got_q[2][95:64]), 32'h10);
    check_eq("init2_data", W'(got_q[2][63:0]), 64'hC0300002_C0300002);
    exp_q = got_q;

    // first Get response corrupted
    do_reset();
    run_traffic(0, 1, 1'b0, 1'b1, 1'b0, 0, to);
    check_eq("corrupt_timeout", W'(to), 0);
    check_eq("corrupt_err", W'(err_count), 1);
    check_eq("corrupt_done_pass", W'({done, pass}), 2'b10);
    check_eq("corrupt_txn", W'(txn_count), 80);

    // 5-cycle a_ready stall on every request
    do_reset();
    run_traffic(5, 1, 1'b0, 1'b0, 1'b0, 0, to);
    check_eq("stall_timeout", W'(to), 0);
    check_eq("stall_stable", W'(unstable), 0);
    check_eq("stall_done_pass", W'({done, pass}), 2'b11);
    check_eq("stall_len", W'(got_q.size()), W'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check_eq($sformatf("stall_trace%0d", i), W'(got_q[i][106:0]), W'(exp_q[i][106:0]));

    // 20+ cycle delayed, reordered responses
    do_reset();
    run_traffic(0, 20, 1'b1, 1'b0, 1'b0, 0, to);
    check_eq("ooo_timeout", W'(to), 0);
    check_eq("ooo_max_out", W'(max_out), 4);
    check_eq("ooo_hazard", W'(hazards), 0);
    check_eq("ooo_proto", W'(proto_bad), 0);
    check_eq("ooo_done_pass", W'({done, pass}), 2'b11);
    check_eq("ooo_txn", W'(txn_count), 80);

    // response on idle source 7
    do_reset();
    run_traffic(0, 1, 1'b0, 1'b0, 1'b1, 0, to);
    check_eq("spur_timeout", W'(to), 0);
    check_eq("spur_err", W'(err_count), 1);
    check_eq("spur_txn", W'(txn_count), 81);
    check_eq("spur_pass", W'(pass), 0);

    // reset in the middle of RUN, then a fresh run
    do_reset();
    run_traffic(0, 1, 1'b0, 1'b0, 1'b0, 10, to);
    check_eq("abort_in_run", W'(dbg_state), 2);
    rst_n = 1'b0; a_ready = 1'b0; d_valid = 1'b0;
    #1;
    check_eq("midrst_a_side", W'({a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data}), 0);
    check_eq("midrst_status", W'({d_ready, busy, done, pass, err_count, txn_count, dbg_state}), 0);
    repeat (2) @(negedge clk);
    check_eq("midrst_hold", W'({a_valid, busy, err_count, txn_count}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    run_traffic(0, 1, 1'b0, 1'b0, 1'b0, 0, to);
    check_eq("rerun_timeout", W'(to), 0);
    check_eq("rerun_done_pass", W'({done, pass}), 2'b11);
    check_eq("rerun_len", W'(got_q.size()), W'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check_eq($sformatf("rerun_trace%0d", i), got_q[i], exp_q[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
